execute_memory_stage: RTL
=========================

# execute_memory_stage

Execute stage plus the Execute/Memory pipeline register of the 5-stage MIPS core. It consumes the registered control and data outputs of the Decode/Execute register and performs operand forwarding, ALUSrc and RegDst selection, the 3-bit-coded ALU operation and the branch-target add. Results are registered into the M-stage outputs that feed data memory and the Memory/Writeback register. It also presents combinational E-stage signals to the hazard unit.

## Interface
- DATA_W, 32, datapath width
- REG_W, 5, register-number width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE  in  1 each  E-stage control
- ALUControlE  in  3  ALU operation
- SrcA_E, RD2_E, SignImm_E, PCPlusOne_E  in  DATA_W  E-stage operands
- Rt_E, Rd_E  in  REG_W  destination candidates
- ForwardAE, ForwardBE  in  2  forwarding selects from hazard unit
- ResultW  in  DATA_W  writeback-stage result for forwarding
- EnM  in  1  register enable (0 = stall, hold M outputs)
- FlushM  in  1  synchronous bubble insert
- WriteRegE  out  REG_W  combinational E destination, for hazard unit
- RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM  out  1  registered
- ALUOutM, WriteDataM, PCBranchM  out  DATA_W  registered
- WriteRegM  out  REG_W  registered
- PCSrcM  out  1  combinational BranchM & ZeroM

## Operation
- Forwarding mux A: ForwardAE 00 → SrcA_E, 01 → ResultW, 10 → ALUOutM, 11 → SrcA_E. Mux B is identical on RD2_E/ForwardBE and produces WriteDataE.
- SrcB = ALUSrcE ? SignImm_E : WriteDataE.
- WriteRegE = RegDstE ? Rd_E : Rt_E.
- ALU ops by ALUControlE: 000 AND; 001 OR; 010 ADD; 110 SUB; 111 SLT (signed, 1 or 0 zero-extended); 100 A & ~B; 101 A | ~B; 011 result 0.
- ADD and SUB wrap modulo 2^DATA_W. Overflow is not flagged.
- ZeroE = (ALU result == 0).
- PCBranchE = PCPlusOne_E + SignImm_E. The PC is word-addressed, so no shift is applied. The add wraps.
- Register update priority is rst_n low, then FlushM, then EnM low, then normal capture.
- Flush: all M control bits (RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM) load 0. Data and WriteRegM also load 0.
- Stall (EnM=0, FlushM=0): every M output holds its value.
- FlushM=1 with EnM=0: the flush wins.

## Timing
- Reset: asynchronous assert, with every registered output at 0 immediately. Deassertion takes effect at the next clock edge.
- PCSrcM is 0 during reset (it is derived from registered signals).
- Latency: E inputs appear on the M outputs one clk edge later.
- WriteRegE and PCSrcM are purely combinational. They have no added cycle.
- Forward 10 uses the current ALUOutM, i.e. the previous instruction's result. This gives back-to-back dependent ALU ops with no stall.
- Reset mid-operation discards the in-flight instruction. The first post-reset capture is the E inputs present at that edge.

## Structure
- Shared package core_pkg holds:
  - ALUControl encodings (ALU_AND=3'b000, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_ANDN, ALU_ORN);
  - forwarding-select encodings (FWD_REG, FWD_WB, FWD_MEM);
  - the DATA_W/REG_W defaults.
- One sub-module is natural: alu (combinational; a, b, ALUControl in; result and zero out). It is reusable by any later branch-compare logic.
- Forwarding muxes, target adder and the register stay in this module.

## Test plan
- After reset, ALUControlE=010, SrcA_E=5, SignImm_E=7, ALUSrcE=1, RegDstE=0, Rt_E=9, one edge → ALUOutM=12, WriteRegM=9, ZeroM=0. WriteRegE=9 before the edge.
- Forwarding: cycle 1 computes 3+4 (ALUOutM=7). Cycle 2 has ForwardAE=10, SUB with RD2_E=7, ALUSrcE=0 → ALUOutM=0, ZeroM=1. With BranchE=1, PCPlusOne_E=20, SignImm_E=0xFFFFFFFC: PCBranchM=16 and PCSrcM=1.
- SLT signed: A=0xFFFFFFFF, B=1, ALUControlE=111 → ALUOutM=1. A=1, B=0xFFFFFFFF → ALUOutM=0.
- Stall and flush:
  - EnM=0 for 3 cycles while the inputs change → all M outputs unchanged.
  - FlushM=1 and EnM=0 with RegWriteE=1 → RegWriteM=0, MemWriteM=0, ALUOutM=0 after the edge.
- Forward 01 with ResultW=0xDEADBEEF, ALUControlE=001, B=0 → ALUOutM=0xDEADBEEF. ForwardAE=11 selects SrcA_E.
- Assert rst_n low mid-cycle with RegWriteM=1 and ALUOutM nonzero → outputs go to 0 without a clock edge. After release, the first edge captures the current E inputs.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings and width defaults for the 5-stage MIPS core.
package core_pkg;

  localparam int CORE_DATA_W = 32;
  localparam int CORE_REG_W  = 5;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_ANDN = 3'b100,
    ALU_ORN  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/execute_memory_stage_if.sv
// E-stage inputs, hazard-unit signals and M-stage outputs of the Execute/Memory boundary.
interface execute_memory_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE;
  logic [2:0]        ALUControlE;
  logic [DATA_W-1:0] SrcA_E, RD2_E, SignImm_E, PCPlusOne_E;
  logic [REG_W-1:0]  Rt_E, Rd_E;
  logic [1:0]        ForwardAE, ForwardBE;
  logic [DATA_W-1:0] ResultW;
  logic              EnM, FlushM;

  logic [REG_W-1:0]  WriteRegE;
  logic              RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM;
  logic [DATA_W-1:0] ALUOutM, WriteDataM, PCBranchM;
  logic [REG_W-1:0]  WriteRegM;
  logic              PCSrcM;

  // master is the upstream/hazard side; slave is the stage itself
  modport master (
    output RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE, ALUControlE,
           SrcA_E, RD2_E, SignImm_E, PCPlusOne_E, Rt_E, Rd_E,
           ForwardAE, ForwardBE, ResultW, EnM, FlushM,
    input  WriteRegE, RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM,
           ALUOutM, WriteDataM, PCBranchM, WriteRegM, PCSrcM
  );

  modport slave (
    input  RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE, ALUControlE,
           SrcA_E, RD2_E, SignImm_E, PCPlusOne_E, Rt_E, Rd_E,
           ForwardAE, ForwardBE, ResultW, EnM, FlushM,
    output WriteRegE, RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM,
           ALUOutM, WriteDataM, PCBranchM, WriteRegM, PCSrcM
  );
endinterface

// File: rtl/execute_memory_stage_alu.sv
// Combinational 3-bit-coded ALU with zero flag; reusable for branch compares.
module alu
  import core_pkg::*;
#(
  parameter int DATA_W = CORE_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        alu_ctrl,
  output logic [DATA_W-1:0] result,
  output logic              zero
);
  logic signed [DATA_W-1:0] w_a_s, w_b_s;

  assign w_a_s = a;
  assign w_b_s = b;

  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, (w_a_s < w_b_s)};
      ALU_ANDN: result = a & ~b;
      ALU_ORN:  result = a | ~b;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);
endmodule

// File: rtl/execute_memory_stage.sv
// Execute stage (forwarding, operand select, ALU, branch target) and the E/M pipeline register.
module execute_memory_stage
  import core_pkg::*;
#(
  parameter int DATA_W = CORE_DATA_W,
  parameter int REG_W  = CORE_REG_W
) (
  input logic                   clk,
  input logic                   rst_n,
  execute_memory_stage_if.slave bus
);
  logic [DATA_W-1:0] w_src_a, w_write_data, w_src_b, w_alu_result, w_pc_branch;
  logic              w_zero;
  logic [REG_W-1:0]  w_write_reg;

  logic              r_regwrite_p1, r_memtoreg_p1, r_memwrite_p1, r_branch_p1, r_zero_p1;
  logic [DATA_W-1:0] r_aluout_p1, r_writedata_p1, r_pcbranch_p1;
  logic [REG_W-1:0]  r_writereg_p1;

  function automatic logic [DATA_W-1:0] fwd_sel(input logic [1:0]        sel,
                                                input logic [DATA_W-1:0] reg_val,
                                                input logic [DATA_W-1:0] wb_val,
                                                input logic [DATA_W-1:0] mem_val);
    case (sel)
      FWD_WB:  return wb_val;
      FWD_MEM: return mem_val;
      default: return reg_val;
    endcase
  endfunction

  // ---- E stage: operand forwarding and selection ----
  assign w_src_a      = fwd_sel(bus.ForwardAE, bus.SrcA_E, bus.ResultW, r_aluout_p1);
  assign w_write_data = fwd_sel(bus.ForwardBE, bus.RD2_E,  bus.ResultW, r_aluout_p1);
  assign w_src_b      = bus.ALUSrcE ? bus.SignImm_E : w_write_data;
  assign w_write_reg  = bus.RegDstE ? bus.Rd_E : bus.Rt_E;
  // Word-addressed PC: the immediate is added unshifted
  assign w_pc_branch  = bus.PCPlusOne_E + bus.SignImm_E;

  alu #(.DATA_W(DATA_W)) u_alu (
    .a        (w_src_a),
    .b        (w_src_b),
    .alu_ctrl (bus.ALUControlE),
    .result   (w_alu_result),
    .zero     (w_zero)
  );

  // ---- E/M boundary register: flush beats stall ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.FlushM) begin
      r_regwrite_p1  <= 1'b0;
      r_memtoreg_p1  <= 1'b0;
      r_memwrite_p1  <= 1'b0;
      r_branch_p1    <= 1'b0;
      r_zero_p1      <= 1'b0;
      r_aluout_p1    <= '0;
      r_writedata_p1 <= '0;
      r_pcbranch_p1  <= '0;
      r_writereg_p1  <= '0;
    end else if (bus.EnM) begin
      r_regwrite_p1  <= bus.RegWriteE;
      r_memtoreg_p1  <= bus.MemtoRegE;
      r_memwrite_p1  <= bus.MemWriteE;
      r_branch_p1    <= bus.BranchE;
      r_zero_p1      <= w_zero;
      r_aluout_p1    <= w_alu_result;
      r_writedata_p1 <= w_write_data;
      r_pcbranch_p1  <= w_pc_branch;
      r_writereg_p1  <= w_write_reg;
    end
  end

  // ---- M stage outputs ----
  assign bus.WriteRegE  = w_write_reg;
  assign bus.RegWriteM  = r_regwrite_p1;
  assign bus.MemtoRegM  = r_memtoreg_p1;
  assign bus.MemWriteM  = r_memwrite_p1;
  assign bus.BranchM    = r_branch_p1;
  assign bus.ZeroM      = r_zero_p1;
  assign bus.ALUOutM    = r_aluout_p1;
  assign bus.WriteDataM = r_writedata_p1;
  assign bus.PCBranchM  = r_pcbranch_p1;
  assign bus.WriteRegM  = r_writereg_p1;
  assign bus.PCSrcM     = r_branch_p1 & r_zero_p1;
endmodule
